log_requant: RTL and testbench

//  Downstream stage of the log-domain MAC array. Takes the signed accumulator result of a

---
 rtl/log_requant.sv | 110 +++++++++++
 tb/tb_log_requant.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/log_requant.sv
// Requantizes a signed MAC accumulator into a {sign, exponent} log code.
// Two-stage valid/ready pipeline with a saturating count of clamped outputs.
module log_requant #(
  parameter int DATA_WIDTH = 4,
  parameter int ACC_WIDTH  = 2**DATA_WIDTH + 6,
  parameter int SHIFT      = 0,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ACC_WIDTH-1:0]  in_acc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_code,
  output logic                  out_zero,
  output logic                  out_ovf,
  output logic [CNT_WIDTH-1:0]  clamp_cnt
);

  localparam int EW      = $clog2(ACC_WIDTH);
  localparam int XW      = 32;
  localparam int EXP_MAX = 2**(DATA_WIDTH-1) - 1;
  localparam logic [DATA_WIDTH-2:0] EXP_ONES = '1;
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = '1;

  logic                  r_s1_valid;
  logic                  r_s1_sign;
  logic                  r_s1_zero;
  logic                  r_s1_rb;
  logic [EW-1:0]         r_s1_e;

  logic                  w_s2_load;
  logic                  w_accept;
  logic                  w_emit;
  logic [ACC_WIDTH-1:0]  w_mag;
  logic [EW-1:0]         w_e;
  logic                  w_rb;
  logic signed [XW-1:0]  w_x;
  logic [DATA_WIDTH-1:0] w_code;
  logic                  w_zero;
  logic                  w_ovf;

  assign w_s2_load = !out_valid || out_ready;
  assign in_ready  = !r_s1_valid || w_s2_load;
  assign w_accept  = in_valid && in_ready;
  assign w_emit    = out_valid && out_ready;

  // Negating the most negative value wraps to 2^(ACC_WIDTH-1), which is the correct unsigned magnitude.
  always_comb begin
    w_mag = in_acc[ACC_WIDTH-1] ? -in_acc : in_acc;
    w_e   = '0;
    w_rb  = 1'b0;
    for (int i = 1; i < ACC_WIDTH; i++) begin
      if (w_mag[i]) begin
        w_e  = EW'(i);
        w_rb = w_mag[i-1];
      end
    end
  end

  always_comb begin
    w_x    = $signed(XW'(r_s1_e) + XW'(r_s1_rb) - XW'(SHIFT));
    w_zero = 1'b0;
    w_ovf  = 1'b0;
    w_code = '0;
    if (r_s1_zero || (w_x < 0)) begin
      w_zero = 1'b1;
    end else if (w_x > EXP_MAX) begin
      w_ovf  = 1'b1;
      w_code = {r_s1_sign, EXP_ONES};
    end else begin
      w_code = {r_s1_sign, w_x[DATA_WIDTH-2:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_zero  <= 1'b0;
      r_s1_rb    <= 1'b0;
      r_s1_e     <= '0;
      out_valid  <= 1'b0;
      out_code   <= '0;
      out_zero   <= 1'b0;
      out_ovf    <= 1'b0;
      clamp_cnt  <= '0;
    end else begin
      if (in_ready) r_s1_valid <= in_valid;
      if (w_accept) begin
        r_s1_sign <= in_acc[ACC_WIDTH-1];
        r_s1_zero <= (in_acc == '0);
        r_s1_e    <= w_e;
        r_s1_rb   <= w_rb;
      end
      if (w_s2_load) begin
        out_valid <= r_s1_valid;
        if (r_s1_valid) begin
          out_code <= w_code;
          out_zero <= w_zero;
          out_ovf  <= w_ovf;
        end
      end
      if (w_emit && out_ovf && (clamp_cnt != CNT_MAX)) clamp_cnt <= clamp_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_log_requant.sv
// Self-checking bench for log_requant: directed steps plus random traffic,
// scored against an arithmetic log-requant model (SHIFT=0 and SHIFT=2 instances).
module tb_log_requant;
  localparam int DW = 4;
  localparam int AW = 22;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [AW-1:0] in_acc = '0;

  logic          in_ready, out_valid, out_zero, out_ovf;
  logic [DW-1:0] out_code;
  logic [15:0]   clamp_cnt;
  logic          in_ready_b, out_valid_b, out_zero_b, out_ovf_b;
  logic [DW-1:0] out_code_b;
  logic [2:0]    clamp_cnt_b;

  int            tests = 0;
  int            fails = 0;
  bit            accepted = 0;
  logic [AW-1:0] q[$];
  int unsigned   cnt_a = 0;
  int unsigned   cnt_b = 0;

  always #5 clk = ~clk;

  log_requant #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .SHIFT(0), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_acc(in_acc),
    .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code), .out_zero(out_zero),
    .out_ovf(out_ovf), .clamp_cnt(clamp_cnt));

  log_requant #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .SHIFT(2), .CNT_WIDTH(3)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b), .in_acc(in_acc),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_code(out_code_b), .out_zero(out_zero_b),
    .out_ovf(out_ovf_b), .clamp_cnt(clamp_cnt_b));

  // Returns {zero, ovf, code}: round log2(|x|) to nearest at the 1.5*2^e point, then bias and clamp.
  function automatic logic [DW+1:0] model(logic [AW-1:0] acc, int shift);
    longint v, mag;
    int e, x;
    logic [DW-2:0] ex;
    v   = longint'($signed(acc));
    mag = (v < 0) ? -v : v;
    if (mag == 0) return {1'b1, 1'b0, {DW{1'b0}}};
    e = 0;
    while ((longint'(2) << e) <= mag) e++;
    if (2 * mag >= (longint'(3) << e)) e++;
    x = e - shift;
    if (x < 0) return {1'b1, 1'b0, {DW{1'b0}}};
    if (x > 2**(DW-1) - 1) return {1'b0, 1'b1, v < 0, {(DW-1){1'b1}}};
    ex = x[DW-2:0];
    return {1'b0, 1'b0, v < 0, ex};
  endfunction

  function automatic logic [AW-1:0] rand_acc();
    int unsigned w = $urandom_range(0, AW);
    logic [AW-1:0] r;
    case ($urandom_range(0, 9))
      0:       r = {1'b1, {(AW-1){1'b0}}};
      1:       r = '0;
      default: begin
        r = AW'($urandom & ((32'd1 << w) - 32'd1));
        if ($urandom_range(0, 1) == 1) r = -r;
      end
    endcase
    return r;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: score outputs and record accepts at the negedge, return #1 after the posedge.
  task automatic cycle();
    logic [DW+1:0] ea, eb;
    @(negedge clk);
    accepted = 0;
    if (!reset) begin
      chk("clamp_cnt", clamp_cnt, cnt_a);
      chk("clamp_cnt_b", clamp_cnt_b, cnt_b);
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out", out_valid, 0);
        end else begin
          ea = model(q[0], 0);
          eb = model(q[0], 2);
          chk("out_a", {out_zero, out_ovf, out_code}, ea);
          chk("out_b", {out_valid_b, out_zero_b, out_ovf_b, out_code_b}, {1'b1, eb});
          if (out_ready) begin
            void'(q.pop_front());
            if (ea[DW] && cnt_a < 65535) cnt_a++;
            if (eb[DW] && cnt_b < 7) cnt_b++;
          end
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(in_acc);
        accepted = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [AW-1:0] a);
    int n = 0;
    in_valid = 1;
    in_acc   = a;
    do begin
      cycle();
      n++;
    end while (!accepted && n < 50);
    chk("send_accept", accepted, 1);
    in_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    in_valid  = 0;
    out_ready = 1;
    while (q.size() != 0 && n < 50) begin
      cycle();
      n++;
    end
    chk("drain_empty", q.size(), 0);
    cycle();
  endtask

  initial begin
    int dir[] = '{-48, 0, 255, -2097152, 3, 1, 10, 20, 30};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_code", out_code, 0);
    chk("rst_out_zero", out_zero, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_clamp_cnt", clamp_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
    reset = 0;

    // Single item: two-cycle latency and the 40 -> 0101 code.
    out_ready = 1;
    in_valid  = 1;
    in_acc    = AW'(40);
    cycle();
    in_valid = 0;
    chk("lat_stage1_valid", out_valid, 0);
    cycle();
    chk("lat_stage2_valid", out_valid, 1);
    chk("code_40", out_code, 4'b0101);
    drain();

    foreach (dir[i]) send(AW'(dir[i]));
    repeat (10) send(AW'(22'h1FFFFF));
    drain();

    // Backpressure: two accepted, third held off while the outputs stay put.
    out_ready = 0;
    in_valid  = 1;
    in_acc    = AW'(10);
    cycle();
    in_acc = AW'(20);
    cycle();
    in_acc = AW'(30);
    cycle();
    chk("stall_in_ready", in_ready, 0);
    chk("stall_accepted", q.size(), 2);
    repeat (3) cycle();
    out_ready = 1;
    for (int n = 0; n < 10 && !accepted; n++) cycle();
    chk("stall_third_accept", accepted, 1);
    drain();

    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 3) != 0);
      in_acc    = rand_acc();
      cycle();
    end
    drain();

    // Reset with both stages occupied discards everything.
    out_ready = 0;
    in_valid  = 1;
    in_acc    = AW'(255);
    repeat (3) cycle();
    chk("full_in_ready", in_ready, 0);
    reset = 1;
    cycle();
    chk("rst2_out_valid", out_valid, 0);
    chk("rst2_clamp_cnt", clamp_cnt, 0);
    chk("rst2_clamp_cnt_b", clamp_cnt_b, 0);
    chk("rst2_in_ready", in_ready, 1);
    chk("rst2_in_ready_b", in_ready_b, 1);
    reset = 0;
    q.delete();
    cnt_a     = 0;
    cnt_b     = 0;
    in_valid  = 0;
    out_ready = 1;
    repeat (4) cycle();
    send(AW'(-3));
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
